// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared definitions for the Wishbone IF/MEM bus arbiter.
//   - arb_state_e : arbiter FSM encoding (IDLE / GNT_IF / GNT_MEM)
//   - SEL_ALL     : all-ones byte-select pattern; callers slice it to their
//                   own SEL_WIDTH (fetches always read the full word)
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } arb_state_e;

  localparam int          SEL_ALL_WIDTH = 64;
  localparam logic [63:0] SEL_ALL       = '1;

endpackage : wb_arb_pkg

// File: rtl/wb_arb_starve_guard.sv
// -----------------------------------------------------------------------------
// wb_arb_starve_guard
//   Grant decision plus the MEM-burst starvation counter. MEM has priority,
//   but only for MEM_BURST_MAX consecutive grants while IF is waiting.
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-low
//   arb_en     in   arbitration strobe (FSM is in IDLE this cycle)
//   mem_elig   in   MEM may be granted this cycle
//   if_elig    in   IF may be granted this cycle
//   if_req     in   raw IF request level (starvation bookkeeping)
//   grant_mem  out  MEM wins this cycle
//   grant_if   out  IF wins this cycle
// -----------------------------------------------------------------------------
module wb_arb_starve_guard #(
  parameter int MEM_BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic mem_elig,
  input  logic if_elig,
  input  logic if_req,
  output logic grant_mem,
  output logic grant_if
);

  localparam int                CNT_W   = $clog2(MEM_BURST_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MEM_BURST_MAX);

  logic [CNT_W-1:0] starve_cnt;

  // NOTE: combinational outputs get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (arb_en) begin
      grant_mem = mem_elig & (~if_elig | (starve_cnt < CNT_MAX));
      grant_if  = if_elig & ~grant_mem;
    end
  end

  // Counts MEM grants taken while IF was requesting; an IF grant or a MEM
  // grant with no IF request outstanding starts the burst over.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_mem) begin
      if (!if_req)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule : wb_arb_starve_guard

// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
//   Shares one Wishbone master port between instruction fetch (IF) and
//   load/store (MEM). Single outstanding bus cycle; arbitration only in IDLE.
//   A flushed fetch still completes on the bus but is not delivered to IF.
// Ports
//   clk, reset                  clock / async active-low reset
//   if_req_i, if_adr_i          fetch request (level) and address
//   if_flush_i                  drop the outstanding fetch
//   if_ack_o, if_dat_o          1-cycle completion pulse and fetched word
//   if_busy_o                   IF request not yet acknowledged
//   mem_req_i, mem_we_i,
//   mem_adr_i, mem_sel_i,
//   mem_dat_i                   load/store request
//   mem_ack_o, mem_dat_o        1-cycle completion pulse and load data
//   mem_busy_o                  MEM request not yet acknowledged
//   wb_cyc_o, wb_stb_o, wb_adr_o,
//   wb_dat_o, wb_we_o, wb_sel_o Wishbone master outputs (registered)
//   wb_ack_i, wb_dat_i          Wishbone slave response
// -----------------------------------------------------------------------------
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SEL_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction fetch side
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_adr_i,
  input  logic                  if_flush_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_dat_o,
  output logic                  if_busy_o,
  // load/store side
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_adr_i,
  input  logic [SEL_WIDTH-1:0]  mem_sel_i,
  input  logic [DATA_WIDTH-1:0] mem_dat_i,
  output logic                  mem_ack_o,
  output logic [DATA_WIDTH-1:0] mem_dat_o,
  output logic                  mem_busy_o,
  // Wishbone master
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_we_o,
  output logic [SEL_WIDTH-1:0]  wb_sel_o,
  input  logic                  wb_ack_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i
);

  arb_state_e state;
  logic       discard;
  logic       mem_elig;
  logic       if_elig;
  logic       grant_mem;
  logic       grant_if;

  // A requester still showing its ack this cycle is the one whose request
  // was just served; re-granting it would repeat the access. A flush in
  // IDLE holds off the fetch for that cycle only.
  assign mem_elig   = mem_req_i & ~mem_ack_o;
  assign if_elig    = if_req_i & ~if_ack_o & ~if_flush_i;

  assign if_busy_o  = if_req_i & ~if_ack_o;
  assign mem_busy_o = mem_req_i & ~mem_ack_o;

  // Strobe mirrors the registered cycle flag (single-beat classic cycles).
  assign wb_stb_o   = wb_cyc_o;

  wb_arb_starve_guard #(
    .MEM_BURST_MAX (MEM_BURST_MAX)
  ) u_starve_guard (
    .clk       (clk),
    .reset     (reset),
    .arb_en    (state == IDLE),
    .mem_elig  (mem_elig),
    .if_elig   (if_elig),
    .if_req    (if_req_i),
    .grant_mem (grant_mem),
    .grant_if  (grant_if)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      discard   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      if_ack_o  <= 1'b0;
      if_dat_o  <= '0;
      mem_ack_o <= 1'b0;
      mem_dat_o <= '0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;

      unique case (state)
        IDLE: begin
          // wb_ack_i is deliberately ignored here: nothing is outstanding.
          if (grant_mem) begin
            state    <= GNT_MEM;
            wb_cyc_o <= 1'b1;
            wb_adr_o <= mem_adr_i;
            wb_dat_o <= mem_dat_i;
            wb_we_o  <= mem_we_i;
            wb_sel_o <= mem_sel_i;
          end else if (grant_if) begin
            state    <= GNT_IF;
            wb_cyc_o <= 1'b1;
            wb_adr_o <= if_adr_i;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= SEL_ALL[SEL_WIDTH-1:0];
          end
        end

        GNT_IF: begin
          if (wb_ack_i) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            discard  <= 1'b0;
            // A fetch flushed at any point of its bus cycle finishes on the
            // bus but is swallowed here.
            if (!(discard || if_flush_i)) begin
              if_dat_o <= wb_dat_i;
              if_ack_o <= 1'b1;
            end
          end else if (if_flush_i) begin
            discard <= 1'b1;
          end
        end

        GNT_MEM: begin
          if (wb_ack_i) begin
            state     <= IDLE;
            wb_cyc_o  <= 1'b0;
            mem_dat_o <= wb_dat_i;
            mem_ack_o <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          wb_cyc_o <= 1'b0;
        end
      endcase
    end
  end

endmodule : wb_bus_arbiter
